stbus_dn_dispatcher: RTL and testbench

STBUS_DN_DISPATCHER -- requirements
Module: stbus_dn_dispatcher

---
 rtl/stbus_dn_dispatcher_pkg.sv | 33 +++
 rtl/stbus_dn_dispatcher_if.sv | 28 ++
 rtl/stbus_dn_dispatcher_fifo.sv | 62 ++++++
 rtl/stbus_dn_dispatcher.sv | 187 ++++++++++++++++++
 tb/tb_stbus_dn_dispatcher.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stbus_dn_dispatcher_pkg.sv
// Shared types and constants for the stack-bus downstream dispatcher:
// FSM state encoding, default widths, watchdog limit and mode decode helper.
package stbus_dn_dispatcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_UCAST = 2'd1,
    ST_BCAST = 2'd2,
    ST_DROP  = 2'd3
  } disp_state_e;

  localparam int DEF_NUM_PE     = 64;
  localparam int DEF_PE_ID_W    = 6;
  localparam int DEF_DATA_W     = 64;
  localparam int DEF_FIFO_DEPTH = 4;

  localparam int              WDOG_W     = 10;
  localparam logic [WDOG_W-1:0] WDOG_LIMIT = 10'd1023;

  // Dispatch mode of a packet from its first-word routing fields
  function automatic disp_state_e decode_mode(input logic bcast, input logic id_ok);
    disp_state_e mode;
    if (bcast) begin
      mode = ST_BCAST;
    end else if (id_ok) begin
      mode = ST_UCAST;
    end else begin
      mode = ST_DROP;
    end
    return mode;
  endfunction

endpackage

// File: rtl/stbus_dn_dispatcher_if.sv
// Manager-to-PE stack bus: manager word handshake plus shared PE payload
// with per-PE valid/ready.
interface stbus_dn_dispatcher_if #(
  parameter int NUM_PE  = 64,
  parameter int PE_ID_W = 6,
  parameter int DATA_W  = 64
);
  logic                mgr_valid;
  logic                mgr_ready;
  logic [PE_ID_W-1:0]  mgr_pe_id;
  logic                mgr_bcast;
  logic [DATA_W-1:0]   mgr_data;
  logic                mgr_last;
  logic [NUM_PE-1:0]   pe_valid;
  logic [NUM_PE-1:0]   pe_ready;
  logic [DATA_W-1:0]   pe_data;
  logic                pe_last;

  modport master (
    output mgr_valid, mgr_pe_id, mgr_bcast, mgr_data, mgr_last, pe_ready,
    input  mgr_ready, pe_valid, pe_data, pe_last
  );

  modport slave (
    input  mgr_valid, mgr_pe_id, mgr_bcast, mgr_data, mgr_last, pe_ready,
    output mgr_ready, pe_valid, pe_data, pe_last
  );
endinterface

// File: rtl/stbus_dn_dispatcher_fifo.sv
// stbus_dn_fifo: power-of-two circular buffer with full/empty/count;
// storage and pointers clear on reset so the head reads zero afterwards.
module stbus_dn_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_poweron,
  input  logic                       srst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage, wrapping pointers and occupancy
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (srst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/stbus_dn_dispatcher.sv
// Stack-bus downstream dispatcher: buffers manager words and delivers them to
// one PE, all PEs, or drops them. Watchdog built when STBUS_DN_DISPATCH_TIMEOUT_EN is defined.
module stbus_dn_dispatcher
  import stbus_dn_dispatcher_pkg::*;
#(
  parameter int NUM_PE     = DEF_NUM_PE,
  parameter int PE_ID_W    = DEF_PE_ID_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_poweron,
  input  logic                  srst,
  stbus_dn_dispatcher_if.slave  bus,
  output logic                  busy,
  output logic                  err_bad_id,
  output logic                  err_timeout
);
  localparam int ENT_W = 1 + PE_ID_W + DATA_W + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [PE_ID_W:0] NUM_PE_L = (PE_ID_W + 1)'(NUM_PE);

  disp_state_e        state_r;
  disp_state_e        mode_s;
  logic               ready_en_r;
  logic               in_pkt_r;
  logic               pkt_bcast_r;
  logic [PE_ID_W-1:0] pkt_id_r;
  logic               err_bad_id_r;
  logic [NUM_PE-1:0]  taken_r;

  logic               push_s;
  logic               pop_s;
  logic               full_s;
  logic               empty_s;
  logic [CNT_W-1:0]   count_s;
  logic [ENT_W-1:0]   wdata_s;
  logic [ENT_W-1:0]   head_s;
  logic               head_bcast_s;
  logic [PE_ID_W-1:0] head_id_s;
  logic [DATA_W-1:0]  head_data_s;
  logic               head_last_s;
  logic               head_id_ok_s;
  logic [NUM_PE-1:0]  target_s;
  logic [NUM_PE-1:0]  valid_s;
  logic [NUM_PE-1:0]  accept_s;

  assign bus.mgr_ready = ready_en_r && !full_s;
  assign push_s        = bus.mgr_valid && bus.mgr_ready;
  // Continuation words inherit the routing captured from the packet's first word
  assign wdata_s = in_pkt_r ? {pkt_bcast_r, pkt_id_r, bus.mgr_data, bus.mgr_last}
                            : {bus.mgr_bcast, bus.mgr_pe_id, bus.mgr_data, bus.mgr_last};

  stbus_dn_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk           (clk),
    .reset_poweron (reset_poweron),
    .srst          (srst),
    .push          (push_s),
    .wdata         (wdata_s),
    .pop           (pop_s),
    .rdata         (head_s),
    .full          (full_s),
    .empty         (empty_s),
    .count         (count_s)
  );

  assign {head_bcast_s, head_id_s, head_data_s, head_last_s} = head_s;
  assign head_id_ok_s = ({1'b0, head_id_s} < NUM_PE_L);

  // One-hot decode of the head word's destination
  always_comb begin
    target_s = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (head_id_s == PE_ID_W'(i)) target_s[i] = 1'b1;
      else                          target_s[i] = 1'b0;
    end
  end

  // IDLE decodes a fresh head in the same cycle so a new word is offered without a bubble
  always_comb begin
    mode_s = state_r;
    if (state_r == ST_IDLE) begin
      if (empty_s) mode_s = ST_IDLE;
      else         mode_s = decode_mode(head_bcast_s, head_id_ok_s);
    end else begin
      mode_s = state_r;
    end
  end

  // Per-mode PE valids and head pop condition
  always_comb begin
    valid_s = '0;
    pop_s   = 1'b0;
    if (empty_s) begin
      valid_s = '0;
      pop_s   = 1'b0;
    end else begin
      case (mode_s)
        ST_UCAST: begin
          valid_s = target_s;
          pop_s   = |(target_s & bus.pe_ready);
        end
        ST_BCAST: begin
          valid_s = ~taken_r;
          pop_s   = &(taken_r | bus.pe_ready);
        end
        ST_DROP: begin
          valid_s = '0;
          pop_s   = 1'b1;
        end
        default: begin
          valid_s = '0;
          pop_s   = 1'b0;
        end
      endcase
    end
  end

  assign accept_s     = valid_s & bus.pe_ready;
  assign bus.pe_valid = valid_s;
  assign bus.pe_data  = head_data_s;
  assign bus.pe_last  = head_last_s;
  assign busy         = (count_s != '0) || (state_r != ST_IDLE);
  assign err_bad_id   = err_bad_id_r;

  // Dispatch FSM, broadcast taken-mask, packet routing latch and error flag
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      state_r      <= ST_IDLE;
      ready_en_r   <= 1'b0;
      in_pkt_r     <= 1'b0;
      pkt_bcast_r  <= 1'b0;
      pkt_id_r     <= '0;
      err_bad_id_r <= 1'b0;
      taken_r      <= '0;
    end else if (srst) begin
      state_r      <= ST_IDLE;
      ready_en_r   <= 1'b0;
      in_pkt_r     <= 1'b0;
      pkt_bcast_r  <= 1'b0;
      pkt_id_r     <= '0;
      err_bad_id_r <= 1'b0;
      taken_r      <= '0;
    end else begin
      ready_en_r <= 1'b1;
      taken_r    <= pop_s ? '0 : (taken_r | accept_s);
      case (mode_s)
        ST_IDLE: state_r <= ST_IDLE;
        default: state_r <= (pop_s && head_last_s) ? ST_IDLE : mode_s;
      endcase
      if ((state_r == ST_IDLE) && (mode_s == ST_DROP)) err_bad_id_r <= 1'b1;
      if (push_s) begin
        in_pkt_r <= !bus.mgr_last;
        if (!in_pkt_r) begin
          pkt_bcast_r <= bus.mgr_bcast;
          pkt_id_r    <= bus.mgr_pe_id;
        end
      end
    end
  end

`ifdef STBUS_DN_DISPATCH_TIMEOUT_EN
  logic [WDOG_W-1:0] wdog_r;
  logic              err_timeout_r;

  // Stall watchdog: counts offered-but-not-popped cycles, flag is sticky
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      wdog_r        <= '0;
      err_timeout_r <= 1'b0;
    end else if (srst) begin
      wdog_r        <= '0;
      err_timeout_r <= 1'b0;
    end else if (pop_s) begin
      wdog_r <= '0;
    end else if ((|valid_s) && (wdog_r != WDOG_LIMIT)) begin
      wdog_r <= wdog_r + 1'b1;
      if (wdog_r == (WDOG_LIMIT - 10'd1)) err_timeout_r <= 1'b1;
    end
  end

  assign err_timeout = err_timeout_r;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_stbus_dn_dispatcher.sv
// Randomized and directed bench for stbus_dn_dispatcher against a
// queue-based model of the dispatch rules.
module tb_stbus_dn_dispatcher;
  localparam int NP    = 6;
  localparam int IDW   = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam logic [NP-1:0] ALL = '1;
`ifdef STBUS_DN_DISPATCH_TIMEOUT_EN
  localparam logic EXP_TO = 1'b1;
`else
  localparam logic EXP_TO = 1'b0;
`endif

  typedef struct {
    logic           bcast;
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    logic           last;
  } word_t;

  logic clk = 1'b0;
  logic reset_poweron = 1'b0;
  logic srst = 1'b0;
  logic busy, err_bad_id, err_timeout;
  int   total = 0;
  int   bad   = 0;

  stbus_dn_dispatcher_if #(.NUM_PE(NP), .PE_ID_W(IDW), .DATA_W(DW)) bus ();

  stbus_dn_dispatcher #(.NUM_PE(NP), .PE_ID_W(IDW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset_poweron (reset_poweron),
    .srst          (srst),
    .bus           (bus.slave),
    .busy          (busy),
    .err_bad_id    (err_bad_id),
    .err_timeout   (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  word_t          q[$];
  logic           m_in_pkt, m_bc, m_mid, m_started, m_bad, m_to;
  logic [IDW-1:0] m_id;
  logic [NP-1:0]  m_got;
  int             m_stall;

  always @(negedge clk) begin : model_chk
    logic [NP-1:0] ev, acc;
    logic          pop, push;
    word_t         h, w;
    if (!reset_poweron) begin
      q.delete();
      m_in_pkt = 1'b0; m_bc = 1'b0; m_id = '0; m_mid = 1'b0;
      m_started = 1'b0; m_bad = 1'b0; m_to = 1'b0; m_got = '0; m_stall = 0;
    end else begin
      ev = '0;
      h  = '{1'b0, '0, '0, 1'b0};
      if (q.size() != 0) begin
        h = q[0];
        if (h.bcast) ev = ALL & ~m_got;
        else if (int'(h.id) < NP) ev[h.id] = 1'b1;
      end
      chk("mgr_ready", bus.mgr_ready, m_started && (q.size() < DEPTH));
      chk("pe_valid", bus.pe_valid, ev);
      chk("busy", busy, (q.size() != 0) || m_mid);
      chk("err_bad_id", err_bad_id, m_bad);
      chk("err_timeout", err_timeout, m_to);
      if (ev != '0) begin
        chk("pe_data", bus.pe_data, h.data);
        chk("pe_last", bus.pe_last, h.last);
      end
      // what the coming rising edge does
      acc  = ev & bus.pe_ready;
      pop  = 1'b0;
      if (q.size() != 0) begin
        if (h.bcast) pop = ((m_got | acc) == ALL);
        else if (int'(h.id) < NP) pop = (acc != '0);
        else pop = 1'b1;
      end
      push = bus.mgr_valid && m_started && (q.size() < DEPTH);
      if (pop) begin
        if (!h.bcast && int'(h.id) >= NP) m_bad = 1'b1;
        m_mid = !h.last;
        void'(q.pop_front());
        m_got = '0;
        m_stall = 0;
      end else begin
        m_got = m_got | acc;
        if (ev != '0) m_stall++;
      end
`ifdef STBUS_DN_DISPATCH_TIMEOUT_EN
      if (m_stall >= 1023) m_to = 1'b1;
`endif
      if (push) begin
        if (!m_in_pkt) begin
          m_bc = bus.mgr_bcast;
          m_id = bus.mgr_pe_id;
        end
        w.bcast = m_bc;
        w.id    = m_id;
        w.data  = bus.mgr_data;
        w.last  = bus.mgr_last;
        m_in_pkt = !bus.mgr_last;
        q.push_back(w);
      end
      m_started = 1'b1;
    end
  end

  // PE2 delivery log for the back-pressure ordering check
  logic [DW-1:0] dlog[$];
  always @(negedge clk) begin
    if (reset_poweron && bus.pe_valid[2] && bus.pe_ready[2]) dlog.push_back(bus.pe_data);
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic bc, input logic [IDW-1:0] id, input logic [DW-1:0] d, input logic l);
    bus.mgr_valid = 1'b1;
    bus.mgr_bcast = bc;
    bus.mgr_pe_id = id;
    bus.mgr_data  = d;
    bus.mgr_last  = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // call at posedge+1; returns at posedge+1 after acceptance
  task automatic send_word(input logic bc, input logic [IDW-1:0] id, input logic [DW-1:0] d, input logic l);
    int n = 0;
    drive(bc, id, d, l);
    @(negedge clk);
    while (!bus.mgr_ready && n < 2000) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (n >= 2000) begin
      bad++;
      $display("FAIL send_word: mgr_ready never rose, got 0 expected 1");
    end
    tick();
    bus.mgr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 500) begin
      n++;
      @(negedge clk);
    end
    chk("idle_bound", (n >= 500), 1'b0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    bus.mgr_valid = 1'b0; bus.mgr_bcast = 1'b0; bus.mgr_pe_id = '0;
    bus.mgr_data = '0; bus.mgr_last = 1'b0; bus.pe_ready = '0;
    #1;
    chk("rst_ready", bus.mgr_ready, 1'b0);
    chk("rst_valid", bus.pe_valid, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", bus.pe_data, '0);
    repeat (3) @(posedge clk);
    #1 reset_poweron = 1'b1;
    @(negedge clk);
    chk("ready_before_edge", bus.mgr_ready, 1'b0);
    tick();

    // unicast 3-word packet to PE 5
    bus.pe_ready = ALL;
    drive(1'b0, 4'd5, 16'hA001, 1'b0);
    @(negedge clk); chk("u_pre_valid", bus.pe_valid, 6'h00);
    tick(); drive(1'b0, 4'd5, 16'hA002, 1'b0);
    @(negedge clk); chk("u1_valid", bus.pe_valid, 6'h20); chk("u1_data", bus.pe_data, 16'hA001);
    chk("u1_last", bus.pe_last, 1'b0);
    tick(); drive(1'b0, 4'd5, 16'hA003, 1'b1);
    @(negedge clk); chk("u2_valid", bus.pe_valid, 6'h20); chk("u2_data", bus.pe_data, 16'hA002);
    tick(); bus.mgr_valid = 1'b0;
    @(negedge clk); chk("u3_valid", bus.pe_valid, 6'h20); chk("u3_data", bus.pe_data, 16'hA003);
    chk("u3_last", bus.pe_last, 1'b1);
    tick();
    @(negedge clk); chk("u_done_valid", bus.pe_valid, 6'h00); chk("u_done_busy", busy, 1'b0);
    tick();

    // broadcast one word with staggered acceptance
    bus.pe_ready = '0;
    drive(1'b1, 4'd3, 16'hB0B0, 1'b1);
    tick(); bus.mgr_valid = 1'b0; bus.pe_ready = 6'b000011;
    @(negedge clk); chk("b1_valid", bus.pe_valid, 6'h3F); chk("b1_data", bus.pe_data, 16'hB0B0);
    tick(); bus.pe_ready = 6'b000011;
    @(negedge clk); chk("b2_valid", bus.pe_valid, 6'h3C);
    tick(); bus.pe_ready = 6'b000100;
    @(negedge clk); chk("b3_valid", bus.pe_valid, 6'h3C); chk("b3_data", bus.pe_data, 16'hB0B0);
    tick(); bus.pe_ready = 6'b111011;
    @(negedge clk); chk("b4_valid", bus.pe_valid, 6'h38); chk("b4_busy", busy, 1'b1);
    tick(); bus.pe_ready = '0;
    @(negedge clk); chk("b5_valid", bus.pe_valid, 6'h00); chk("b5_busy", busy, 1'b0);
    tick();

    // bad id packet dropped, then a good one
    bus.pe_ready = ALL;
    drive(1'b0, 4'd9, 16'hBAD1, 1'b0);
    tick(); drive(1'b0, 4'd0, 16'hBAD2, 1'b1);
    @(negedge clk); chk("d1_valid", bus.pe_valid, 6'h00); chk("d1_err", err_bad_id, 1'b0);
    tick(); drive(1'b0, 4'd1, 16'hC001, 1'b1);
    @(negedge clk); chk("d2_valid", bus.pe_valid, 6'h00); chk("d2_err", err_bad_id, 1'b1);
    tick(); bus.mgr_valid = 1'b0;
    @(negedge clk); chk("d3_valid", bus.pe_valid, 6'h02); chk("d3_data", bus.pe_data, 16'hC001);
    tick();
    wait_idle();

    // back-pressure: PE2 stalled, FIFO fills after 4 words
    dlog.delete();
    bus.pe_ready = '0;
    send_word(1'b0, 4'd2, 16'hD000, 1'b0);
    send_word(1'b1, 4'd7, 16'hD001, 1'b0);
    send_word(1'b1, 4'd7, 16'hD002, 1'b0);
    send_word(1'b0, 4'd7, 16'hD003, 1'b0);
    drive(1'b1, 4'd7, 16'hD004, 1'b0);
    @(negedge clk); chk("bp_ready_full", bus.mgr_ready, 1'b0); chk("bp_valid", bus.pe_valid, 6'h04);
    repeat (3) begin
      tick();
      @(negedge clk); chk("bp_ready_hold", bus.mgr_ready, 1'b0);
    end
    tick(); bus.pe_ready = ALL;
    send_word(1'b1, 4'd7, 16'hD004, 1'b0);
    send_word(1'b0, 4'd0, 16'hD005, 1'b1);
    wait_idle();
    chk("bp_count", dlog.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (k < dlog.size()) chk("bp_order", dlog[k], 16'hD000 + 16'(k));
    end

    // reset asserted mid-packet
    bus.pe_ready = '0;
    send_word(1'b0, 4'd3, 16'hE001, 1'b0);
    @(posedge clk); #3 reset_poweron = 1'b0;
    #1;
    chk("ar_valid", bus.pe_valid, '0); chk("ar_ready", bus.mgr_ready, 1'b0);
    chk("ar_busy", busy, 1'b0); chk("ar_err", err_bad_id, 1'b0);
    chk("ar_data", bus.pe_data, '0); chk("ar_last", bus.pe_last, 1'b0);
    chk("ar_to", err_timeout, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset_poweron = 1'b1;
    @(negedge clk); chk("ar_ready_pre", bus.mgr_ready, 1'b0);
    tick();
    @(negedge clk); chk("ar_ready_post", bus.mgr_ready, 1'b1);
    tick();
    bus.pe_ready = ALL;
    send_word(1'b0, 4'd1, 16'hE101, 1'b0);
    @(negedge clk); chk("ar_pkt_valid", bus.pe_valid, 6'h02); chk("ar_pkt_data", bus.pe_data, 16'hE101);
    tick();
    send_word(1'b0, 4'd4, 16'hE102, 1'b1);
    @(negedge clk); chk("ar_pkt2_valid", bus.pe_valid, 6'h02); chk("ar_pkt2_last", bus.pe_last, 1'b1);
    tick();
    wait_idle();

    // watchdog: target stalled well beyond 1023 cycles
    bus.pe_ready = '0;
    send_word(1'b0, 4'd4, 16'hF001, 1'b1);
    repeat (1000) @(posedge clk);
    @(negedge clk); chk("to_early", err_timeout, 1'b0);
    repeat (40) @(posedge clk);
    @(negedge clk); chk("to_late", err_timeout, EXP_TO);
    tick(); bus.pe_ready = ALL;
    wait_idle();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bus.mgr_valid = ($urandom_range(0, 9) < 7);
      bus.mgr_bcast = ($urandom_range(0, 4) == 0);
      bus.mgr_pe_id = IDW'($urandom_range(0, 9));
      bus.mgr_data  = DW'($urandom);
      bus.mgr_last  = ($urandom_range(0, 2) == 0);
      for (int p = 0; p < NP; p++) bus.pe_ready[p] = ($urandom_range(0, 9) < 6);
      tick();
    end
    bus.mgr_valid = 1'b0;
    bus.pe_ready  = ALL;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
